// File: rtl/_exec_sequencer.sv
// _exec_sequencer: fetch/decode/execute/writeback sequencer with multi-cycle ALU handshake and timeout.
module _exec_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        instr_req,
  input  logic        instr_valid,
  input  logic [31:0] instr_data,
  output logic [7:0]  pc,
  output logic [31:0] ir,
  input  logic [5:0]  op,
  output logic        alu_start,
  input  logic        alu_done,
  output logic        reg_we,
  output logic        reg_we2,
  output logic        busy,
  output logic        halted,
  output logic        err,
  output logic [15:0] retired,
  output logic [2:0]  state
);
  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3,
                         WAIT_ALU = 3'd4, WB = 3'd5, HALTED = 3'd6;
  logic [5:0] op_r;
  logic [3:0] cnt;
  logic       is_alu, is_std;
  assign is_alu = op_r == 6'd4 || op_r == 6'd5;
  assign is_std = op_r inside {6'd1, 6'd2, 6'd3, 6'd6, 6'd7};
  assign instr_req = state == FETCH;
  assign alu_start = state == EXEC && is_alu;
  assign reg_we = state == WB && op_r != 6'd3;
  assign reg_we2 = state == WB && op_r == 6'd3;
  assign busy = state inside {FETCH, DECODE, EXEC, WAIT_ALU, WB};
  assign halted = state == HALTED;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc <= '0;
      ir <= '0;
      op_r <= '0;
      err <= 1'b0;
      retired <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE, HALTED: if (start) begin
          state <= FETCH;
          pc <= '0;
          err <= 1'b0;
          retired <= '0;
        end
        FETCH: if (instr_valid) begin
          ir <= instr_data;
          state <= DECODE;
        end
        DECODE: begin
          op_r <= op;
          state <= EXEC;
        end
        EXEC: begin
          cnt <= '0;
          if (op_r == 6'd0) state <= HALTED;
          else if (is_alu) state <= WAIT_ALU;
          else if (is_std) state <= WB;
          else begin
            err <= 1'b1;
            pc <= pc + 8'd1;
            state <= FETCH;
          end
        end
        WAIT_ALU: if (alu_done) state <= WB;
        else if (cnt == 4'hF) begin
          err <= 1'b1;
          pc <= pc + 8'd1;
          state <= FETCH;
        end else cnt <= cnt + 4'd1;
        WB: begin
          pc <= pc + 8'd1;
          retired <= retired + 16'(retired != 16'hFFFF);
          state <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb__exec_sequencer.sv
// tb__exec_sequencer: directed program runs with a write scoreboard, fetch/ALU responders and a decode model.
module tb__exec_sequencer;
  logic        clk, rst, start, instr_req, instr_valid, alu_start, alu_done;
  logic        reg_we, reg_we2, busy, halted, err;
  logic [31:0] instr_data, ir;
  logic [7:0]  pc;
  logic [5:0]  op;
  logic [15:0] retired;
  logic [2:0]  state;
  int tests = 0, fails = 0;
  int fetch_delay = 0, alu_lat = 0;
  logic [31:0] mem [256];
  typedef struct packed {logic we; logic we2; logic [7:0] pc;} wr_t;
  wr_t sb [$];

  _exec_sequencer dut (.clk(clk), .rst(rst), .start(start), .instr_req(instr_req),
    .instr_valid(instr_valid), .instr_data(instr_data), .pc(pc), .ir(ir), .op(op),
    .alu_start(alu_start), .alu_done(alu_done), .reg_we(reg_we), .reg_we2(reg_we2),
    .busy(busy), .halted(halted), .err(err), .retired(retired), .state(state));

  assign op = ir[31:26];

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ins(input logic [5:0] o);
    return {o, 26'h0ABCDE};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic go();
    start = 1;
    tick(1);
    start = 0;
  endtask

  task automatic wait_halted();
    for (int i = 0; i < 200 && !halted; i++) tick(1);
    chk("halt_reached", halted, 1);
  endtask

  task automatic push(input logic we, input logic we2, input logic [7:0] p);
    sb.push_back('{we: we, we2: we2, pc: p});
  endtask

  // Fetch responder: holds off instr_valid for fetch_delay cycles and drives junk (illegal op 9) meanwhile
  initial begin
    int wcnt;
    wcnt = 0;
    instr_valid = 0;
    instr_data = '0;
    forever begin
      @(negedge clk);
      if (instr_req) begin
        instr_valid = wcnt >= fetch_delay;
        instr_data = instr_valid ? mem[pc] : ins(6'd9);
        wcnt++;
      end else begin
        instr_valid = 0;
        wcnt = 0;
      end
    end
  end

  initial begin
    int acnt;
    acnt = 0;
    alu_done = 0;
    forever begin
      @(negedge clk);
      if (state == 3'd4) begin
        acnt++;
        alu_done = alu_lat != 0 && acnt == alu_lat;
      end else begin
        acnt = 0;
        alu_done = 0;
      end
    end
  end

  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (reg_we || reg_we2) begin
        if (sb.size() == 0) chk("sb_unexpected_write", {reg_we, reg_we2, pc}, 0);
        else begin
          e = sb.pop_front();
          chk("sb_write", {reg_we, reg_we2, pc}, {e.we, e.we2, e.pc});
        end
      end
    end
  end

  initial begin
    rst = 1;
    start = 0;
    foreach (mem[i]) mem[i] = ins(6'd0);
    @(negedge clk);
    tick(3);
    chk("rst_state", state, 0);
    chk("rst_outs", {instr_req, alu_start, reg_we, reg_we2, busy, halted, err}, 0);
    chk("rst_regs", {pc, retired}, 0);
    chk("rst_ir", ir, 0);
    start = 1;
    tick(1);
    chk("rst_over_start", state, 0);
    rst = 0;
    start = 0;
    tick(1);
    chk("idle_hold", state, 0);

    mem[0] = ins(6'd1); mem[1] = ins(6'd2); mem[2] = ins(6'd0);
    push(1, 0, 0); push(1, 0, 1);
    go();
    chk("prog_busy", {busy, instr_req}, 2'b11);
    tick(3);
    chk("prog_wb1", {state, reg_we}, {3'd5, 1'b1});
    tick(4);
    chk("prog_wb2", {state, reg_we, pc}, {3'd5, 1'b1, 8'd1});
    tick(4);
    chk("prog_halted", {halted, busy}, 2'b10);
    chk("prog_pc", pc, 2);
    chk("prog_retired", retired, 2);

    mem[0] = ins(6'd3); mem[1] = ins(6'd0);
    fetch_delay = 3;
    push(0, 1, 0);
    go();
    for (int i = 0; i < 4; i++) begin
      chk("mov_req_held", instr_req, 1);
      tick(1);
    end
    chk("mov_decode", {state, instr_req}, {3'd2, 1'b0});
    chk("mov_ir", ir, ins(6'd3));
    wait_halted();
    chk("mov_retired", {retired, pc}, {16'd1, 8'd1});
    fetch_delay = 0;

    mem[0] = ins(6'd4);
    alu_lat = 5;
    push(1, 0, 0);
    go();
    tick(2);
    chk("div_alu_start", {state, alu_start}, {3'd3, 1'b1});
    tick(1);
    chk("div_alu_start_drop", alu_start, 0);
    for (int i = 0; i < 5; i++) begin
      chk("div_wait", state, 4);
      tick(1);
    end
    chk("div_wb", {state, reg_we}, {3'd5, 1'b1});
    tick(1);
    chk("div_pc", {state, pc}, {3'd1, 8'd1});
    wait_halted();
    chk("div_retired", {retired, err}, {16'd1, 1'b0});

    mem[0] = ins(6'd5);
    alu_lat = 0;
    go();
    tick(3);
    for (int i = 0; i < 16; i++) begin
      chk("mul_wait", {state, err}, {3'd4, 1'b0});
      tick(1);
    end
    chk("mul_timeout", {state, err, pc}, {3'd1, 1'b1, 8'd1});
    wait_halted();
    chk("mul_sticky", {err, retired}, {1'b1, 16'd0});

    mem[0] = ins(6'd10); mem[1] = ins(6'd1); mem[2] = ins(6'd0);
    push(1, 0, 1);
    go();
    chk("ill_err_cleared", err, 0);
    tick(2);
    chk("ill_no_strobe", {state, alu_start, reg_we, reg_we2}, {3'd3, 3'b000});
    tick(1);
    chk("ill_err", {state, err, pc, retired}, {3'd1, 1'b1, 8'd1, 16'd0});
    wait_halted();
    chk("ill_end", {err, pc, retired}, {1'b1, 8'd2, 16'd1});

    foreach (mem[i]) mem[i] = ins(6'd1);
    for (int i = 0; i < 256; i++) push(1, 0, 8'(i));
    go();
    tick(1020);
    chk("wrap_pre", {pc, retired}, {8'd255, 16'd255});
    mem[0] = ins(6'd0);
    tick(4);
    chk("wrap_pc", {state, pc, err}, {3'd1, 8'd0, 1'b0});
    chk("wrap_retired", retired, 256);
    tick(3);
    chk("wrap_halted", {halted, pc, retired}, {1'b1, 8'd0, 16'd256});

    mem[0] = ins(6'd5);
    go();
    tick(5);
    chk("rstw_in_wait", state, 4);
    rst = 1;
    tick(1);
    chk("rstw_state", state, 0);
    chk("rstw_outs", {instr_req, alu_start, reg_we, reg_we2, busy, halted, err}, 0);
    chk("rstw_regs", {pc, retired, ir}, 0);
    rst = 0;
    mem[0] = ins(6'd1); mem[1] = ins(6'd0);
    push(1, 0, 0);
    go();
    chk("rstw_restart", {state, pc}, {3'd1, 8'd0});
    wait_halted();
    chk("rstw_end", {pc, retired}, {8'd1, 16'd1});
    tick(2);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/_exec_sequencer.md
_EXEC_SEQUENCER -- requirements
Module: _exec_sequencer

Interface
REQ-001 SHALL have port: clk  in  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  reset; synchronous, active-high.
REQ-003 SHALL have port: start  in  1  begin program execution; sampled only in IDLE or HALTED.
REQ-004 SHALL have ports: instr_req  out  1  fetch request; instr_valid  in  1  fetch data valid; instr_data  in  32  fetched word.
REQ-005 SHALL have port: pc  out  8  address of the instruction being fetched or executed.
REQ-006 SHALL have port: ir  out  32  latched instruction; feeds the combinational control unit.
REQ-007 SHALL have port: op  in  6  decoded operation from the control unit (1 SUMA, 2 RESTA, 3 MOV, 4 DIV, 5 MUL, 6 AND, 7 OR, 0 HALT).
REQ-008 SHALL have ports: alu_start  out  1  start pulse for multi-cycle ops; alu_done  in  1  multi-cycle op complete.
REQ-009 SHALL have ports: reg_we  out  1  register-file write strobe (ALU result); reg_we2  out  1  register-file write strobe (MOV immediate path).
REQ-010 SHALL have ports: busy  out  1; halted  out  1; err  out  1 (sticky); retired  out  16; state  out  3 (debug encoding).

Function
REQ-011 SHALL implement states IDLE=0, FETCH=1, DECODE=2, EXEC=3, WAIT_ALU=4, WB=5, HALTED=6.
REQ-012 IDLE/HALTED: start=1 -> FETCH next cycle; pc<=0, err<=0, retired<=0.
REQ-013 FETCH: instr_req=1 every cycle until instr_valid=1; on that cycle ir<=instr_data, -> DECODE; instr_data ignored when instr_valid=0.
REQ-014 DECODE: exactly one cycle; op sampled at end of DECODE into an internal op register; -> EXEC.
REQ-015 EXEC with op in {1,2,3,6,7}: one cycle, -> WB.
REQ-016 EXEC with op in {4,5}: alu_start=1 for exactly this one cycle, -> WAIT_ALU.
REQ-017 WAIT_ALU: -> WB on the first cycle alu_done=1; alu_done sampled only in WAIT_ALU.
REQ-018 WAIT_ALU timeout: 4-bit counter cleared on entry; if alu_done not seen within 16 cycles, err<=1, no write, pc<=pc+1, -> FETCH.
REQ-019 WB: one cycle; reg_we=1 for op in {1,2,4,5,6,7}, reg_we2=1 for op 3, never both; pc<=pc+1; retired<=retired+1; -> FETCH.
REQ-020 EXEC with op=0: -> HALTED; pc unchanged (points at HALT word); no write strobe; retired unchanged.
REQ-021 EXEC with op in 8..63: err<=1, no write strobe, pc<=pc+1, retired unchanged, -> FETCH.
REQ-022 pc SHALL wrap 255 -> 0 without error.
REQ-023 retired SHALL saturate at 16'hFFFF.
REQ-024 reg_we, reg_we2, alu_start SHALL be registered-free decodes of current state and op register, glitch-free at clock edge; zero in all states other than those stated.
REQ-025 busy=1 in FETCH..WB; halted=1 only in HALTED; start ignored in states 1..5.
REQ-026 Instruction latency without waits: FETCH(1)+DECODE(1)+EXEC(1)+WB(1)=4 cycles; DIV/MUL add WAIT_ALU cycles (min 1).

Reset
REQ-027 rst=1 at any clock edge, including mid-FETCH or WAIT_ALU, SHALL force next state IDLE, pc=0, ir=0, op register=0, err=0, retired=0, timeout counter=0.
REQ-028 During and after reset until start: instr_req=0, alu_start=0, reg_we=0, reg_we2=0, busy=0, halted=0, state=0.
REQ-029 rst SHALL take priority over start on the same edge.

Verification
REQ-030 Program {SUMA, RESTA, HALT}, instr_valid same cycle as instr_req -> reg_we pulses at cycles 4 and 8 after start, halted=1, pc=2, retired=2.
REQ-031 MOV op, instr_valid delayed 3 cycles -> instr_req held 4 cycles, reg_we2 single pulse, reg_we=0, retired=1.
REQ-032 DIV with alu_done after 5 cycles -> alu_start one-cycle pulse, state=4 for 5 cycles, then reg_we pulse, pc+1.
REQ-033 MUL with alu_done never asserted -> after 16 WAIT_ALU cycles err=1, no reg_we, pc+1, fetch resumes.
REQ-034 Op=6'b001010 -> err=1, no strobes, retired unchanged; 256 SUMA ops -> pc wraps to 0, retired=256.
REQ-035 rst asserted during WAIT_ALU -> next cycle state=0, all outputs per REQ-028; later start restarts at pc=0.
